// File: rtl/control_riego_if.sv
// Signal bundle between the watering controller, the humidity front end and the pump.
// The master side is the watering controller; the slave side is its environment.
interface control_riego_if;
  logic       MODbomba;
  logic [3:0] maceta;
  logic [6:0] humedad;
  logic       humedad_valida;
  logic       activarB;
  logic       regar;
  logic       fallo;
  logic [7:0] num_riegos;
  logic [2:0] estado;

  modport master (
    input  MODbomba, maceta, humedad, humedad_valida, activarB,
    output regar, fallo, num_riegos, estado
  );

  modport slave (
    output MODbomba, maceta, humedad, humedad_valida, activarB,
    input  regar, fallo, num_riegos, estado
  );
endinterface

// File: rtl/control_riego.sv
// Watering-decision FSM: debounces dry humidity samples, requests the pump, supervises
// its start/stop with timeouts, enforces a soak period and latches a sticky fault.
module control_riego #(
  parameter int unsigned UMBRAL         = 20,
  parameter int unsigned MUESTRAS_BAJAS = 3,
  parameter logic [63:0] T_ACK          = 64'd50_000_000,
  parameter logic [63:0] T_RIEGO_MAX    = 64'd5_000_000_000,
  parameter logic [63:0] T_ESPERA       = 64'd30_000_000_000
) (
  input  logic             clk,
  input  logic             rst_n,
  control_riego_if.master  bus
);

  typedef enum logic [2:0] {
    MONITOR   = 3'd0,
    SOLICITAR = 3'd1,
    REGANDO   = 3'd2,
    ESPERA    = 3'd3,
    FALLO     = 3'd4
  } estado_t;

  localparam logic [6:0] UMBRAL_L = 7'(UMBRAL);
  localparam logic [3:0] MB_L     = 4'(MUESTRAS_BAJAS);

  estado_t     state_q, state_d;
  logic [63:0] timer_q, timer_d;
  logic [3:0]  dry_q, dry_d;
  logic [7:0]  num_q, num_d;
  logic        regar_q, fallo_q;
  logic        maceta_ok;
  logic        sample_ok;

  assign maceta_ok = (bus.maceta >= 4'd1) && (bus.maceta <= 4'd3);
  assign sample_ok = bus.humedad_valida && (bus.humedad <= 7'd100);

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    dry_d   = dry_q;
    num_d   = num_q;
    if (!bus.MODbomba) begin
      state_d = MONITOR;
      timer_d = '0;
      dry_d   = '0;
    end else begin
      case (state_q)
        MONITOR: begin
          timer_d = '0;
          if (sample_ok) begin
            if (bus.humedad < UMBRAL_L) begin
              if (dry_q < MB_L) dry_d = dry_q + 4'd1;
            end else begin
              dry_d = '0;
            end
          end
          // Decide on the updated count so the request follows the last dry strobe directly.
          if ((dry_d == MB_L) && maceta_ok) state_d = SOLICITAR;
        end
        SOLICITAR: begin
          timer_d = timer_q + 64'd1;
          if (bus.activarB) begin
            state_d = REGANDO;
            timer_d = '0;
          end else if (timer_q == T_ACK - 64'd1) begin
            state_d = FALLO;
          end
        end
        REGANDO: begin
          timer_d = timer_q + 64'd1;
          if (!bus.activarB) begin
            state_d = ESPERA;
            timer_d = '0;
            dry_d   = '0;
            if (num_q != 8'hFF) num_d = num_q + 8'd1;
          end else if (timer_q == T_RIEGO_MAX - 64'd1) begin
            state_d = FALLO;
          end
        end
        ESPERA: begin
          timer_d = timer_q + 64'd1;
          if (timer_q == T_ESPERA - 64'd1) begin
            state_d = MONITOR;
            timer_d = '0;
          end
        end
        FALLO: begin
          timer_d = '0;
        end
        default: begin
          state_d = MONITOR;
          timer_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= MONITOR;
      timer_q <= '0;
      dry_q   <= '0;
      num_q   <= '0;
      regar_q <= 1'b0;
      fallo_q <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      dry_q   <= dry_d;
      num_q   <= num_d;
      regar_q <= (state_d == SOLICITAR);
      fallo_q <= (state_d == FALLO);
    end
  end

  assign bus.regar      = regar_q;
  assign bus.fallo      = fallo_q;
  assign bus.num_riegos = num_q;
  assign bus.estado     = state_q;

endmodule

// File: doc/control_riego.md
Name: control_riego

Overview:
- Watering-decision initiator: drives the `regar` request into the pump controller and watches its `activarB` feedback.
- Consumes strobed soil-humidity samples (percent) from the sensor front end.
- Requests watering after N consecutive dry samples, drops the request once the pump starts, then enforces a soak period before re-evaluating.
- Detects a pump that never starts or never stops, and raises a sticky fault.

Parameters:
- UMBRAL, 20, dry threshold in percent; a sample < UMBRAL counts as dry.
- MUESTRAS_BAJAS, 3, consecutive dry samples required to request watering (1..15).
- T_ACK, 50_000_000, max cycles in SOLICITAR waiting for activarB=1 (1 s at 50 MHz).
- T_RIEGO_MAX, 5_000_000_000, max cycles activarB may stay high (100 s).
- T_ESPERA, 30_000_000_000, soak cycles after watering (600 s).
- Counters are 64 bits wide.

Ports:
- clk  in  1  system clock, 50 MHz.
- rst_n  in  1  synchronous reset, active-low.
- MODbomba  in  1  pump module connected/enabled.
- maceta  in  4  pot size; valid values 1..3.
- humedad  in  7  humidity percent 0..100; values >100 are invalid.
- humedad_valida  in  1  one-cycle strobe, humedad valid.
- activarB  in  1  pump-running feedback from the pump controller.
- regar  out  1  watering request to the pump.
- fallo  out  1  sticky pump fault.
- num_riegos  out  8  completed waterings, saturating at 255.
- estado  out  3  FSM state: MONITOR=0, SOLICITAR=1, REGANDO=2, ESPERA=3, FALLO=4.

Behaviour:
- **Clocking and reset:** one clock domain; all outputs registered.
- rst_n=0 at a clk edge gives estado=MONITOR, regar=0, fallo=0, num_riegos=0, dry counter=0, timer=0.
- Reset mid-operation aborts any request immediately.
- **Output decode:** regar=1 exactly while estado=SOLICITAR; fallo=1 exactly while estado=FALLO.
- **Pump disconnected:** MODbomba=0 forces next state MONITOR from any state, including FALLO; dry counter and timer are cleared; num_riegos is held.
- **MONITOR:**
  - On humedad_valida with humedad ≤100: dry counter increments if humedad < UMBRAL (saturating at MUESTRAS_BAJAS), otherwise clears to 0.
  - humedad >100 is ignored; the counter is unchanged.
  - Go to SOLICITAR on the edge where the counter equals MUESTRAS_BAJAS and maceta ∈ {1,2,3}.
  - If maceta is invalid, stay in MONITOR with the counter saturated; leave as soon as maceta becomes valid.
  - The timer is 0 on entry to SOLICITAR.
- **SOLICITAR:**
  - Timer increments every cycle.
  - If activarB=1, go to REGANDO and clear the timer. This has priority over timeout.
  - Else if timer == T_ACK-1, go to FALLO. regar is therefore high for at most T_ACK cycles.
  - Samples are ignored.
- **REGANDO:**
  - regar=0, so the pump does not re-trigger after it finishes.
  - Timer increments.
  - If activarB=0, go to ESPERA, increment num_riegos (saturating), clear the timer and the dry counter.
  - Else if timer == T_RIEGO_MAX-1, go to FALLO.
- **ESPERA:** samples are ignored; timer increments; when timer == T_ESPERA-1, go to MONITOR and clear the timer.
- **FALLO:** regar=0, fallo=1; exit only by rst_n=0 or MODbomba=0.
- **Typical latency:** with the companion pump, activarB rises 2 cycles after regar rises, so SOLICITAR lasts 3 cycles.

Test Plan:
Bench parameters: UMBRAL=20, MUESTRAS_BAJAS=3, T_ACK=8, T_RIEGO_MAX=32, T_ESPERA=16. Pump model raises activarB 2 cycles after regar and holds it 10 cycles.
- Reset: hold rst_n=0 for 2 cycles with all inputs toggling -> estado=0, regar=0, fallo=0, num_riegos=0.
- Dry trigger: maceta=2, samples 15,12,19 -> regar=1 the cycle after the 3rd strobe, 3 cycles long. Then REGANDO for 10 cycles, ESPERA for 16, back to MONITOR; num_riegos=1.
- Debounce: samples 15,12,25,10,10 -> no request. Adding a 3rd consecutive dry sample (10) triggers the request. A sample of 120 between dry samples does not break the run.
- Ack timeout: pump model disabled -> regar high for exactly 8 cycles, then estado=4, fallo=1 sticky. MODbomba pulsed low for 1 cycle -> estado=0, fallo=0.
- Stuck pump: activarB held high for 40 cycles -> FALLO after 32 cycles in REGANDO, with regar=0 throughout REGANDO.
- Guards: maceta=0 with 3 dry samples -> stays in MONITOR; setting maceta=1 requests next cycle. Samples during ESPERA do not re-trigger. rst_n low during SOLICITAR -> regar=0 next edge. num_riegos saturates at 255 after 256 cycles.
